risc_fetch_ctrl: RTL
====================

// Module: risc_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the 13-bit RISC core. Owns the fetch PC, requests instruction
//  words from instruction memory over a req/ack handshake, and presents them to decode
//  as ir/pc with a valid flag. Supports stall, branch redirect and halt.
//  Sits between instruction memory and decode, in place of a free-running fetch.
// PARAMETERS
//  IW   13       instruction width
//  AW   5        PC / instruction-address width (wraps modulo 2**AW)
//  NOP  13'h0000 instruction driven on ir whenever ir_valid=0
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  mem_req    out  1   fetch request to instruction memory
//  mem_addr   out  AW  fetch address, valid while mem_req=1
//  mem_ack    in   1   memory returns mem_rdata this cycle (only meaningful while mem_req=1)
//  mem_rdata  in   IW  instruction word, sampled when mem_req & mem_ack
//  stall      in   1   decode cannot accept; hold current ir
//  br_taken   in   1   one-cycle redirect pulse from execute
//  br_target  in   AW  redirect address, sampled with br_taken
//  halt       in   1   level; stop fetching after current instruction is consumed
//  ir         out  IW  instruction to decode
//  pc         out  AW  address of the instruction in ir
//  ir_valid   out  1   ir holds a live instruction
//  halted     out  1   high in HALTED state
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, fpc=0, redir_pend=0, ir=NOP, pc=0, ir_valid=0,
//   mem_req=0, halted=0. Takes effect immediately, including mid-handshake.
//  States: IDLE, FETCH, ISSUE, HALTED. All outputs registered. mem_addr=fpc.
//  IDLE: one cycle after reset release; halt ? HALTED : FETCH.
//  FETCH: mem_req=1. mem_addr and mem_req stay stable until mem_ack (any number of waits).
//   On mem_ack with redir_pend=0 and br_taken=0: ir<=mem_rdata, pc<=fpc, ir_valid<=1,
//   fpc<=fpc+1 (31->0 at AW=5), go ISSUE. Zero-wait ack gives ir_valid 2 cycles after
//   entering FETCH (entry cycle + register).
//  Redirect in FETCH: br_taken without ack -> redir_tgt<=br_target, redir_pend<=1,
//   keep requesting old address. On ack with redir_pend or br_taken: discard mem_rdata,
//   fpc<=(br_taken ? br_target : redir_tgt), redir_pend<=0, mem_req<=0 for one cycle, then
//   re-request. A newer br_taken overwrites redir_tgt.
//  ISSUE: ir_valid=1, ir/pc held. Priority per cycle: br_taken > stall > halt.
//   br_taken: ir<=NOP, ir_valid<=0, fpc<=br_target, go FETCH.
//   stall=1: hold everything, mem_req=0.
//   stall=0: instruction consumed this cycle; halt ? HALTED : FETCH; ir_valid<=0, ir<=NOP.
//  HALTED: halted=1, mem_req=0, ir=NOP, ir_valid=0. br_taken updates fpc.
//   halt=0 -> FETCH at fpc next cycle.
//  halt asserted during FETCH does not abort the handshake; it is honoured in ISSUE.
//  Back-to-back throughput with zero-wait memory and no stall: one instruction / 2 cycles.
// TESTING
//  1 rst_n=0 mid-FETCH with mem_req=1 -> same cycle mem_req=0, ir=13'h0000, pc=0,
//    ir_valid=0; after release, first mem_addr=0.
//  2 zero-wait ack, rdata=addr+13'h100, no stall -> ir 0x100,0x101,... with pc 0,1,...;
//    after pc=31, next mem_addr=0 (wrap).
//  3 ack delayed 3 cycles at addr 4 -> mem_req=1, mem_addr=4 stable 4 cycles; ir=rdata, pc=4.
//  4 stall=1 for 3 cycles in ISSUE at pc=2 -> ir/pc/ir_valid held, mem_req=0;
//    next mem_addr=3.
//  5 br_taken target=20 while FETCH addr 7 waits; ack 2 cycles later -> rdata discarded,
//    ir_valid stays 0, next request mem_addr=20.
//  6 halt=1 in ISSUE pc=9 with stall=0 -> HALTED, halted=1, mem_req=0; br_taken target 5,
//    then halt=0 -> mem_addr=5.

Source files
------------

// File: rtl/risc_fetch_ctrl.sv
// risc_fetch_ctrl: fetch sequencer for the 13-bit RISC core.
// It owns the fetch PC and requests instruction words from instruction memory
// over a req/ack handshake. It presents each word to decode as ir/pc with a valid flag,
// and it handles stall, branch redirect and halt.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_req/mem_addr      fetch request and address (address = fetch PC)
//   mem_ack/mem_rdata     memory response, sampled while mem_req=1
//   stall                 decode cannot accept the current instruction
//   br_taken/br_target    one-cycle redirect from execute
//   halt                  level request to stop fetching
//   ir/pc/ir_valid        instruction, its address and live flag to decode
//   halted                high while in the HALTED state
module risc_fetch_ctrl #(
  parameter int unsigned    IW  = 13,
  parameter int unsigned    AW  = 5,
  parameter logic [IW-1:0]  NOP = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          halt,
  output logic [IW-1:0] ir,
  output logic [AW-1:0] pc,
  output logic          ir_valid,
  output logic          halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   fpc_q, fpc_d;
  logic [AW-1:0]   redir_tgt_q, redir_tgt_d;
  logic            redir_pend_q, redir_pend_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic            mem_req_q, mem_req_d;
  logic            halted_q, halted_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fpc_q        <= '0;
      redir_tgt_q  <= '0;
      redir_pend_q <= 1'b0;
      ir_q         <= NOP;
      pc_q         <= '0;
      ir_valid_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fpc_q        <= fpc_d;
      redir_tgt_q  <= redir_tgt_d;
      redir_pend_q <= redir_pend_d;
      ir_q         <= ir_d;
      pc_q         <= pc_d;
      ir_valid_q   <= ir_valid_d;
      mem_req_q    <= mem_req_d;
      halted_q     <= halted_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    fpc_d        = fpc_q;
    redir_tgt_d  = redir_tgt_q;
    redir_pend_d = redir_pend_q;
    ir_d         = ir_q;
    pc_d         = pc_q;
    ir_valid_d   = ir_valid_q;
    mem_req_d    = mem_req_q;
    halted_d     = halted_q;

    case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end else begin
          state_d   = S_FETCH;
          mem_req_d = 1'b1;
        end
      end

      S_FETCH: begin
        if (!mem_req_q) begin
          // Bubble after a discarded response: re-request at the redirected PC
          mem_req_d = 1'b1;
          if (br_taken) fpc_d = br_target;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          if (redir_pend_q || br_taken) begin
            // Response belongs to the abandoned path; drop it
            fpc_d        = br_taken ? br_target : redir_tgt_q;
            redir_pend_d = 1'b0;
          end else begin
            ir_d       = mem_rdata;
            pc_d       = fpc_q;
            ir_valid_d = 1'b1;
            fpc_d      = fpc_q + AW'(1);
            state_d    = S_ISSUE;
          end
        end else if (br_taken) begin
          // Handshake must complete at the old address; remember where to go
          redir_tgt_d  = br_target;
          redir_pend_d = 1'b1;
        end
      end

      S_ISSUE: begin
        if (br_taken) begin
          ir_d       = NOP;
          ir_valid_d = 1'b0;
          fpc_d      = br_target;
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
        end else if (!stall) begin
          ir_d       = NOP;
          ir_valid_d = 1'b0;
          if (halt) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end else begin
            state_d   = S_FETCH;
            mem_req_d = 1'b1;
          end
        end
      end

      S_HALTED: begin
        if (br_taken) fpc_d = br_target;
        if (!halt) begin
          state_d   = S_FETCH;
          halted_d  = 1'b0;
          mem_req_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = fpc_q;
  assign ir       = ir_q;
  assign pc       = pc_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;

endmodule
